// File: rtl/mips_rf_pkg.sv
// Shared register-file types: write request record, grant source, and a
// helper that maps a destination register to its one-hot busy bit.
package mips_rf_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_HEAD
  } wb_grant_e;

  // $0 is hard-wired, so it never shows up as busy
  function automatic logic [NUM_REGS-1:0] regMask(input logic [REG_AW-1:0] wa);
    regMask     = '0;
    regMask[wa] = (wa != '0);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order queue of long-latency write requests with a per-register busy map
// built from the valid entries (driven to zero when BUSY_EN is clear).
module rf_wb_fifo
  import mips_rf_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter bit BUSY_EN = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  wb_req_t             push_data_i,
  input  logic                pop_i,
  output wb_req_t             head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  wb_req_t          mem_q [DEPTH];
  logic             pushEn;
  logic             popEn;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    nextPtr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign head_o  = mem_q[rdPtr_q];
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;

  always_comb begin
    vld_d   = vld_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (pushEn) begin
      vld_d[wrPtr_q] = 1'b1;
      wrPtr_d        = nextPtr(wrPtr_q);
    end
    if (popEn) begin
      vld_d[rdPtr_q] = 1'b0;
      rdPtr_d        = nextPtr(rdPtr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
    end
  end

  // Payload storage is only meaningful under a valid bit, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  generate
    if (BUSY_EN) begin : g_busy
      always_comb begin
        busy_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i]) begin
            busy_o = busy_o | regMask(mem_q[i].wa);
          end
        end
      end
    end else begin : g_no_busy
      assign busy_o = '0;
    end
  endgenerate

endmodule

// File: rtl/rf_wb_arbiter.sv
// GPR write-port arbiter: W stage has priority, long-latency results queue and
// force a one-cycle pipe stall after MAX_WAIT lost cycles. RF_WB_SCOREBOARD_EN enables ll_busy.
module rf_wb_arbiter
  import mips_rf_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_we,
  input  logic [REG_AW-1:0]   pipe_wa,
  input  logic [DATA_W-1:0]   pipe_wd,
  input  logic [DATA_W-1:0]   pipe_pc,
  output logic                pipe_stall,
  input  logic                ll_valid,
  output logic                ll_ready,
  input  logic [REG_AW-1:0]   ll_wa,
  input  logic [DATA_W-1:0]   ll_wd,
  input  logic [DATA_W-1:0]   ll_pc,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_wa,
  output logic [DATA_W-1:0]   rf_wd,
  output logic [DATA_W-1:0]   rf_pc,
  output logic [NUM_REGS-1:0] ll_busy
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SCOREBOARD_EN = 1'b1;
`else
  localparam bit SCOREBOARD_EN = 1'b0;
`endif

  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  wb_req_t          llReq;
  wb_req_t          head;
  wb_grant_e        grant;
  logic             full;
  logic             empty;
  logic             pipeReq;
  logic             starve;
  logic             pop;

  assign llReq   = '{wa: ll_wa, wd: ll_wd, pc: ll_pc};
  assign pipeReq = pipe_we && (pipe_wa != '0);
  assign starve  = !empty && (waitCnt_q == CNT_W'(MAX_WAIT));

  rf_wb_fifo #(
    .DEPTH   (DEPTH),
    .BUSY_EN (SCOREBOARD_EN)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (ll_valid && !full),
    .push_data_i (llReq),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .busy_o      (ll_busy)
  );

  // The wait counter only advances while a queued head actually loses to the pipe
  always_comb begin
    grant     = GRANT_NONE;
    waitCnt_d = '0;
    if (starve) begin
      grant = GRANT_HEAD;
    end else if (pipeReq) begin
      grant = GRANT_PIPE;
      if (!empty) begin
        waitCnt_d = waitCnt_q + CNT_W'(1);
      end
    end else if (!empty) begin
      grant = GRANT_HEAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  assign pop        = (grant == GRANT_HEAD);
  assign pipe_stall = starve;
  assign ll_ready   = !full;

  // Reset gates the write strobe so a held W-stage request cannot reach the RF
  assign rf_we = rst && ((grant == GRANT_PIPE) || (pop && (head.wa != '0)));
  assign rf_wa = pop ? head.wa : pipe_wa;
  assign rf_wd = pop ? head.wd : pipe_wd;
  assign rf_pc = pop ? head.pc : pipe_pc;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: inputs change 1ns after posedge, outputs
// are sampled on the negedge of the same cycle.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we, ll_valid;
  logic [4:0]  pipe_wa, ll_wa;
  logic [31:0] pipe_wd, pipe_pc, ll_wd, ll_pc;
  logic        pipe_stall, ll_ready, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_pc, ll_busy;

  int checks = 0;
  int fails  = 0;

`ifdef RF_WB_SCOREBOARD_EN
  localparam logic [31:0] BUSY12 = 32'h0000_1000;
`else
  localparam logic [31:0] BUSY12 = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd), .ll_pc(ll_pc),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_pc(rf_pc), .ll_busy(ll_busy)
  );

  task automatic idleInputs();
    pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0; pipe_pc = '0;
    ll_valid = 1'b0; ll_wa = '0; ll_wd = '0; ll_pc = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h3333; pipe_pc = 32'h10;
    ll_valid = 1'b1; ll_wa = 5'd4; ll_wd = 32'h4444; ll_pc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      midCycle();
      checks++;
      if ({ll_ready, rf_we, pipe_stall} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL reset_ctrl: ready/we/stall got %b expected 100", {ll_ready, rf_we, pipe_stall});
      end
      checks++;
      if (ll_busy !== 32'h0) begin
        fails++;
        $display("[TB] FAIL reset_busy: got %h expected 00000000", ll_busy);
      end
    end
    nextCycle();
    rst = 1'b1;
    pipe_we = 1'b0;
    midCycle();
    checks++;
    if ({ll_ready, rf_we} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL release_idle: ready/we got %b expected 10", {ll_ready, rf_we});
    end
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd4, 32'h4444}) begin
      fails++;
      $display("[TB] FAIL release_accept: we/wa/wd got %b/%0d/%h expected 1/4/00004444", rf_we, rf_wa, rf_wd);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, ll_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL release_drained: we/ready got %b expected 01", {rf_we, ll_ready});
    end
  endtask

  task automatic test_idle_pipe();
    nextCycle();
    idleInputs();
    ll_valid = 1'b1; ll_wa = 5'd5; ll_wd = 32'hDEAD_BEEF; ll_pc = 32'h100;
    midCycle();
    checks++;
    if ({rf_we, ll_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL idle_no_bypass: we/ready got %b expected 01", {rf_we, ll_ready});
    end
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd, rf_pc} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h100}) begin
      fails++;
      $display("[TB] FAIL idle_grant: we/wa/wd/pc got %b/%0d/%h/%h expected 1/5/deadbeef/00000100",
               rf_we, rf_wa, rf_wd, rf_pc);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, ll_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL idle_empty: we/ready got %b expected 01", {rf_we, ll_ready});
    end
  endtask

  task automatic test_contention();
    nextCycle();
    idleInputs();
    pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h33; pipe_pc = 32'h200;
    ll_valid = 1'b1; ll_wa = 5'd7; ll_wd = 32'h77; ll_pc = 32'h300;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, pipe_stall} !== {1'b1, 5'd3, 1'b0}) begin
      fails++;
      $display("[TB] FAIL cont_push: we/wa/stall got %b/%0d/%b expected 1/3/0", rf_we, rf_wa, pipe_stall);
    end
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      ll_valid = 1'b0;
      midCycle();
      checks++;
      if ({rf_we, rf_wa, pipe_stall} !== {1'b1, 5'd3, 1'b0}) begin
        fails++;
        $display("[TB] FAIL cont_pipe_wins_%0d: we/wa/stall got %b/%0d/%b expected 1/3/0",
                 i, rf_we, rf_wa, pipe_stall);
      end
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd, pipe_stall} !== {1'b1, 5'd7, 32'h77, 1'b1}) begin
      fails++;
      $display("[TB] FAIL cont_starve: we/wa/wd/stall got %b/%0d/%h/%b expected 1/7/00000077/1",
               rf_we, rf_wa, rf_wd, pipe_stall);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, rf_wa, pipe_stall} !== {1'b1, 5'd3, 1'b0}) begin
      fails++;
      $display("[TB] FAIL cont_after_stall: we/wa/stall got %b/%0d/%b expected 1/3/0", rf_we, rf_wa, pipe_stall);
    end
  endtask

  task automatic test_full_queue();
    nextCycle();
    idleInputs();
    pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h33;
    ll_valid = 1'b1; ll_wa = 5'd10; ll_wd = 32'hA;
    midCycle();
    checks++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_ready0: got %b expected 1", ll_ready);
    end
    nextCycle();
    ll_wa = 5'd11; ll_wd = 32'hB;
    midCycle();
    checks++;
    if (ll_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_ready1: got %b expected 1", ll_ready);
    end
    nextCycle();
    ll_wa = 5'd12; ll_wd = 32'hC;
    for (int c = 2; c <= 5; c++) begin
      midCycle();
      checks++;
      if (ll_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL full_not_ready_c%0d: got %b expected 0", c, ll_ready);
      end
      checks++;
      if (c == 5) begin
        if ({pipe_stall, rf_we, rf_wa} !== {1'b1, 1'b1, 5'd10}) begin
          fails++;
          $display("[TB] FAIL full_starve: stall/we/wa got %b/%b/%0d expected 1/1/10", pipe_stall, rf_we, rf_wa);
        end
      end else begin
        if ({pipe_stall, rf_wa} !== {1'b0, 5'd3}) begin
          fails++;
          $display("[TB] FAIL full_pipe_c%0d: stall/wa got %b/%0d expected 0/3", c, pipe_stall, rf_wa);
        end
        nextCycle();
      end
    end
    nextCycle();
    midCycle();
    checks++;
    if ({ll_ready, pipe_stall, rf_wa} !== {1'b1, 1'b0, 5'd3}) begin
      fails++;
      $display("[TB] FAIL full_reopen: ready/stall/wa got %b/%b/%0d expected 1/0/3", ll_ready, pipe_stall, rf_wa);
    end
    nextCycle();
    ll_valid = 1'b0; pipe_we = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa} !== {1'b1, 5'd11}) begin
      fails++;
      $display("[TB] FAIL full_drain_b: we/wa got %b/%0d expected 1/11", rf_we, rf_wa);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd12, 32'hC}) begin
      fails++;
      $display("[TB] FAIL full_drain_c: we/wa/wd got %b/%0d/%h expected 1/12/0000000c", rf_we, rf_wa, rf_wd);
    end
    nextCycle();
    midCycle();
    checks++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_empty: we got %b expected 0", rf_we);
    end
  endtask

  task automatic test_zero_filter();
    nextCycle();
    idleInputs();
    pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hBAD;
    ll_valid = 1'b1; ll_wa = 5'd9; ll_wd = 32'h99;
    midCycle();
    checks++;
    if ({rf_we, pipe_stall} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL zero_pipe_filtered: we/stall got %b expected 00", {rf_we, pipe_stall});
    end
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, pipe_stall} !== {1'b1, 5'd9, 1'b0}) begin
      fails++;
      $display("[TB] FAIL zero_ll_granted: we/wa/stall got %b/%0d/%b expected 1/9/0", rf_we, rf_wa, pipe_stall);
    end
    nextCycle();
    pipe_we = 1'b0;
    ll_valid = 1'b1; ll_wa = 5'd0; ll_wd = 32'hBAD0;
    midCycle();
    checks++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_push: we got %b expected 0", rf_we);
    end
    nextCycle();
    ll_wa = 5'd14; ll_wd = 32'hE;
    midCycle();
    checks++;
    if ({rf_we, ll_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL zero_head_pop: we/ready got %b expected 01", {rf_we, ll_ready});
    end
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd14, 32'hE}) begin
      fails++;
      $display("[TB] FAIL zero_next_head: we/wa/wd got %b/%0d/%h expected 1/14/0000000e", rf_we, rf_wa, rf_wd);
    end
    nextCycle();
    midCycle();
    checks++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_empty: we got %b expected 0", rf_we);
    end
  endtask

  task automatic test_scoreboard();
    nextCycle();
    idleInputs();
    pipe_we = 1'b1; pipe_wa = 5'd3;
    ll_valid = 1'b1; ll_wa = 5'd12; ll_wd = 32'h1;
    midCycle();
    checks++;
    if (ll_busy !== 32'h0) begin
      fails++;
      $display("[TB] FAIL sb_before_push: got %h expected 00000000", ll_busy);
    end
    nextCycle();
    ll_wd = 32'h2;
    midCycle();
    checks++;
    if (ll_busy !== BUSY12) begin
      fails++;
      $display("[TB] FAIL sb_one_entry: got %h expected %h", ll_busy, BUSY12);
    end
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if ({ll_busy, ll_ready} !== {BUSY12, 1'b0}) begin
      fails++;
      $display("[TB] FAIL sb_two_entries: busy/ready got %h/%b expected %h/0", ll_busy, ll_ready, BUSY12);
    end
    nextCycle();
    pipe_we = 1'b0;
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd, ll_busy} !== {1'b1, 5'd12, 32'h1, BUSY12}) begin
      fails++;
      $display("[TB] FAIL sb_first_pop: we/wa/wd/busy got %b/%0d/%h/%h expected 1/12/00000001/%h",
               rf_we, rf_wa, rf_wd, ll_busy, BUSY12);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd12, 32'h2}) begin
      fails++;
      $display("[TB] FAIL sb_second_pop: we/wa/wd got %b/%0d/%h expected 1/12/00000002", rf_we, rf_wa, rf_wd);
    end
    nextCycle();
    midCycle();
    checks++;
    if ({ll_busy, rf_we} !== {32'h0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL sb_cleared: busy/we got %h/%b expected 00000000/0", ll_busy, rf_we);
    end
  endtask

  task automatic test_reset_mid_queue();
    nextCycle();
    idleInputs();
    pipe_we = 1'b1; pipe_wa = 5'd3;
    ll_valid = 1'b1; ll_wa = 5'd20; ll_wd = 32'h20;
    nextCycle();
    ll_wa = 5'd21; ll_wd = 32'h21;
    nextCycle();
    ll_valid = 1'b0;
    midCycle();
    checks++;
    if (ll_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_full: ready got %b expected 0", ll_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rf_we, pipe_stall, ll_ready, ll_busy} !== {3'b001, 32'h0}) begin
      fails++;
      $display("[TB] FAIL mid_async_reset: we/stall/ready/busy got %b/%b/%b/%h expected 0/0/1/00000000",
               rf_we, pipe_stall, ll_ready, ll_busy);
    end
    nextCycle();
    rst = 1'b1;
    pipe_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      midCycle();
      checks++;
      if ({rf_we, ll_ready} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL mid_no_stale_%0d: we/ready got %b expected 01", i, {rf_we, ll_ready});
      end
      nextCycle();
    end
  endtask

  initial begin
    idleInputs();
    $display("[TB] starting rf_wb_arbiter directed tests");
    test_reset();
    test_idle_pipe();
    test_contention();
    test_full_queue();
    test_zero_filter();
    test_scoreboard();
    test_reset_mid_queue();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
